// File: rtl/rib_rr_arbiter_pkg.sv
// Shared definitions for the RIB round-robin arbiter: state encodings, park master,
// handshake/hold levels and the timeout counter width helper.
package rib_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        RIB_ARB_IDLE = 2'd0,
        RIB_ARB_BUSY = 2'd1,
        RIB_ARB_ERR  = 2'd2
    } rib_arb_state_e;

    localparam int   RIB_PARK_MASTER = 1;

    localparam logic RIB_REQ     = 1'b1;
    localparam logic RIB_ACK     = 1'b1;
    localparam logic HoldEnable  = 1'b1;
    localparam logic HoldDisable = 1'b0;

    // Timeout counter is 8 bits for small limits, 16 bits otherwise.
    function automatic int rib_cnt_width(input int cycles);
        return (cycles < 256) ? 8 : 16;
    endfunction

endpackage

// File: rtl/rib_rr_pick.sv
// Combinational rotating priority encoder: first set request strictly above last_id,
// otherwise the lowest set request overall (so last_id itself ranks last).
module rib_rr_pick
    import rib_rr_arbiter_pkg::*;
#(
    parameter  int NUM_MASTERS = 3,
    localparam int IDW         = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDW-1:0]         last_id,
    output logic                   valid,
    output logic [IDW-1:0]         pick_id
);

    logic [NUM_MASTERS-1:0]        w_above;
    logic [NUM_MASTERS-1:0]        w_req_hi;
    logic [NUM_MASTERS:0][IDW-1:0] w_lo_hi;
    logic [NUM_MASTERS:0][IDW-1:0] w_lo_all;

    assign w_lo_hi[NUM_MASTERS]  = '0;
    assign w_lo_all[NUM_MASTERS] = '0;

    // Downward chains leave the lowest set index at position 0.
    for (genvar g = NUM_MASTERS - 1; g >= 0; g--) begin : g_chain
        assign w_above[g]  = (IDW'(g) > last_id);
        assign w_req_hi[g] = req[g] & w_above[g];
        assign w_lo_hi[g]  = w_req_hi[g] ? IDW'(g) : w_lo_hi[g+1];
        assign w_lo_all[g] = req[g]      ? IDW'(g) : w_lo_all[g+1];
    end

    assign valid   = |req;
    assign pick_id = (|w_req_hi) ? w_lo_hi[0] : w_lo_all[0];

endmodule

// File: rtl/rib_rr_arbiter.sv
// Registered round-robin arbiter / transaction sequencer for the RIB master ports.
// Optional bus timeout with ERR state enabled by defining RIB_ARB_TIMEOUT_EN.
module rib_rr_arbiter
    import rib_rr_arbiter_pkg::*;
#(
    parameter  int NUM_MASTERS    = 3,
    parameter  int PARK_ID        = RIB_PARK_MASTER,
    parameter  int TIMEOUT_CYCLES = 255,
    localparam int IDW            = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic                   ack_i,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic [IDW-1:0]         grant_id_o,
    output logic                   busy_o,
    output logic                   hold_flag_o,
    output logic                   err_o,
    output logic [IDW-1:0]         err_id_o
);

    localparam logic [IDW-1:0]         PARK_IDX  = IDW'(PARK_ID);
    localparam logic [NUM_MASTERS-1:0] PARK_MASK = NUM_MASTERS'(1) << PARK_ID;

    rib_arb_state_e         r_state;
    rib_arb_state_e         w_state_nxt;
    logic [IDW-1:0]         r_grant_id;
    logic [IDW-1:0]         w_grant_id_nxt;
    logic [IDW-1:0]         r_last_id;
    logic [IDW-1:0]         w_last_id_nxt;
    logic [NUM_MASTERS-1:0] r_grant;
    logic                   w_pick_vld;
    logic [IDW-1:0]         w_pick_id;
    logic                   w_cur_req;
    logic                   w_ack;
    logic                   w_tmo_hit;
    logic                   w_hold;

    rib_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_pick (
        .req     (req_i),
        .last_id (r_last_id),
        .valid   (w_pick_vld),
        .pick_id (w_pick_id)
    );

    assign w_cur_req = (req_i[r_grant_id] == RIB_REQ);
    assign w_ack     = (ack_i == RIB_ACK);

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_id_nxt = r_grant_id;
        w_last_id_nxt  = r_last_id;
        case (r_state)
            RIB_ARB_IDLE: begin
                w_grant_id_nxt = PARK_IDX;
                if (w_pick_vld) begin
                    w_state_nxt    = RIB_ARB_BUSY;
                    w_grant_id_nxt = w_pick_id;
                    w_last_id_nxt  = w_pick_id;
                end
            end
            RIB_ARB_BUSY: begin
                // Abort takes precedence: an ack for a dropped request is ignored.
                if (!w_cur_req) begin
                    w_state_nxt    = RIB_ARB_IDLE;
                    w_grant_id_nxt = PARK_IDX;
                end else if (w_ack) begin
                    if (w_pick_vld) begin
                        w_grant_id_nxt = w_pick_id;
                        w_last_id_nxt  = w_pick_id;
                    end else begin
                        w_state_nxt    = RIB_ARB_IDLE;
                        w_grant_id_nxt = PARK_IDX;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nxt    = RIB_ARB_ERR;
                    w_grant_id_nxt = PARK_IDX;
                end
            end
            default: begin
                w_state_nxt    = RIB_ARB_IDLE;
                w_grant_id_nxt = PARK_IDX;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RIB_ARB_IDLE;
            r_grant_id <= PARK_IDX;
            r_last_id  <= PARK_IDX;
            r_grant    <= PARK_MASK;
        end else begin
            r_state    <= w_state_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_last_id  <= w_last_id_nxt;
            r_grant    <= NUM_MASTERS'(1) << w_grant_id_nxt;
        end
    end

    assign grant_o    = r_grant;
    assign grant_id_o = r_grant_id;
    assign busy_o     = (r_state == RIB_ARB_BUSY);

    // The park master fetching on its own never stalls the pipeline.
    assign w_hold      = (|(req_i & ~PARK_MASK)) || (busy_o && (r_grant_id != PARK_IDX));
    assign hold_flag_o = (!rst && w_hold) ? HoldEnable : HoldDisable;

`ifdef RIB_ARB_TIMEOUT_EN
    localparam int             CNTW     = rib_cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNTW-1:0] TMO_LAST = CNTW'(TIMEOUT_CYCLES - 1);

    logic [CNTW-1:0] r_tmo_cnt;
    logic [IDW-1:0]  r_err_id;

    assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);

    // Count only consecutive un-acked BUSY cycles of the same transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            r_err_id  <= '0;
        end else begin
            if (r_state == RIB_ARB_BUSY && w_state_nxt == RIB_ARB_BUSY && !w_ack)
                r_tmo_cnt <= r_tmo_cnt + CNTW'(1);
            else
                r_tmo_cnt <= '0;
            if (r_state == RIB_ARB_BUSY && w_state_nxt == RIB_ARB_ERR)
                r_err_id <= r_grant_id;
        end
    end

    assign err_o    = (r_state == RIB_ARB_ERR);
    assign err_id_o = r_err_id;
`else
    logic w_unused_tmo;

    assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
    assign w_tmo_hit    = 1'b0;
    assign err_o        = 1'b0;
    assign err_id_o     = '0;
`endif

endmodule

// File: tb/tb_rib_rr_arbiter.sv
// Directed bench for rib_rr_arbiter (3 masters, park on 1, timeout of 4 cycles).
module tb_rib_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req_i = 3'b000;
    logic       ack_i = 1'b0;
    logic [2:0] grant_o;
    logic [1:0] grant_id_o;
    logic       busy_o;
    logic       hold_flag_o;
    logic       err_o;
    logic [1:0] err_id_o;

    int checks   = 0;
    int failures = 0;

    rib_rr_arbiter #(
        .NUM_MASTERS    (3),
        .PARK_ID        (1),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req_i),
        .ack_i       (ack_i),
        .grant_o     (grant_o),
        .grant_id_o  (grant_id_o),
        .busy_o      (busy_o),
        .hold_flag_o (hold_flag_o),
        .err_o       (err_o),
        .err_id_o    (err_id_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1; req_i = 3'b000; ack_i = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_i = 3'b000; ack_i = 1'b0;
        step();
        req_i = 3'b001;
        #1;
        checks++; if (hold_flag_o !== 1'b0) begin failures++; $display("FAIL reset_hold_in_rst got=%b exp=0", hold_flag_o); end
        req_i = 3'b000;
        step();
        checks++; if (grant_o !== 3'b010) begin failures++; $display("FAIL reset_grant got=%b exp=010", grant_o); end
        checks++; if (grant_id_o !== 2'd1) begin failures++; $display("FAIL reset_grant_id got=%0d exp=1", grant_id_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_o); end
        checks++; if (err_id_o !== 2'd0) begin failures++; $display("FAIL reset_err_id got=%0d exp=0", err_id_o); end
        checks++; if (hold_flag_o !== 1'b0) begin failures++; $display("FAIL reset_hold got=%b exp=0", hold_flag_o); end
        rst = 1'b0;
        step();
        checks++; if (grant_o !== 3'b010 || busy_o !== 1'b0) begin failures++; $display("FAIL idle_park grant=%b busy=%b exp=010/0", grant_o, busy_o); end
        checks++; if (hold_flag_o !== 1'b0) begin failures++; $display("FAIL idle_hold got=%b exp=0", hold_flag_o); end
    endtask

    task automatic test_single();
        req_i = 3'b001;
        #1;
        checks++; if (hold_flag_o !== 1'b1) begin failures++; $display("FAIL single_hold_req got=%b exp=1", hold_flag_o); end
        step();
        checks++; if (grant_o !== 3'b001 || grant_id_o !== 2'd0) begin failures++; $display("FAIL single_grant got=%b/%0d exp=001/0", grant_o, grant_id_o); end
        checks++; if (busy_o !== 1'b1 || hold_flag_o !== 1'b1) begin failures++; $display("FAIL single_busy busy=%b hold=%b exp=1/1", busy_o, hold_flag_o); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (grant_o !== 3'b001 || busy_o !== 1'b1 || hold_flag_o !== 1'b1) begin failures++; $display("FAIL single_wait%0d grant=%b busy=%b hold=%b exp=001/1/1", i, grant_o, busy_o, hold_flag_o); end
        end
        ack_i = 1'b1;
        step();
        checks++; if (grant_id_o !== 2'd0 || busy_o !== 1'b1) begin failures++; $display("FAIL single_self_regrant id=%0d busy=%b exp=0/1", grant_id_o, busy_o); end
        ack_i = 1'b0; req_i = 3'b000;
        #1;
        checks++; if (hold_flag_o !== 1'b1) begin failures++; $display("FAIL single_hold_busy got=%b exp=1", hold_flag_o); end
        step();
        checks++; if (grant_o !== 3'b010 || busy_o !== 1'b0 || hold_flag_o !== 1'b0) begin failures++; $display("FAIL single_park grant=%b busy=%b hold=%b exp=010/0/0", grant_o, busy_o, hold_flag_o); end
    endtask

    task automatic test_park_master();
        req_i = 3'b010;
        #1;
        checks++; if (hold_flag_o !== 1'b0) begin failures++; $display("FAIL park_req_hold got=%b exp=0", hold_flag_o); end
        step();
        checks++; if (grant_id_o !== 2'd1 || busy_o !== 1'b1 || hold_flag_o !== 1'b0) begin failures++; $display("FAIL park_busy id=%0d busy=%b hold=%b exp=1/1/0", grant_id_o, busy_o, hold_flag_o); end
        req_i = 3'b000;
        step();
        checks++; if (grant_id_o !== 2'd1 || busy_o !== 1'b0) begin failures++; $display("FAIL park_release id=%0d busy=%b exp=1/0", grant_id_o, busy_o); end
    endtask

    task automatic test_back_to_back();
        int exp_seq[5] = '{2, 0, 1, 2, 0};
        logic [2:0] exp_gnt;
        pulse_reset();
        req_i = 3'b111; ack_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            exp_gnt = 3'b001 << exp_seq[i];
            checks++; if (grant_id_o !== 2'(exp_seq[i]) || grant_o !== exp_gnt || busy_o !== 1'b1) begin failures++; $display("FAIL b2b_%0d id=%0d grant=%b busy=%b exp=%0d/%b/1", i, grant_id_o, grant_o, busy_o, exp_seq[i], exp_gnt); end
        end
        req_i = 3'b000; ack_i = 1'b0;
        step();
        checks++; if (busy_o !== 1'b0 || grant_id_o !== 2'd1) begin failures++; $display("FAIL b2b_idle busy=%b id=%0d exp=0/1", busy_o, grant_id_o); end
    endtask

    task automatic test_abort();
        req_i = 3'b100;
        step();
        checks++; if (grant_id_o !== 2'd2 || busy_o !== 1'b1) begin failures++; $display("FAIL abort_grant id=%0d busy=%b exp=2/1", grant_id_o, busy_o); end
        step();
        checks++; if (grant_id_o !== 2'd2 || hold_flag_o !== 1'b1) begin failures++; $display("FAIL abort_hold id=%0d hold=%b exp=2/1", grant_id_o, hold_flag_o); end
        req_i = 3'b000; ack_i = 1'b1;
        step();
        checks++; if (grant_id_o !== 2'd1 || grant_o !== 3'b010 || busy_o !== 1'b0) begin failures++; $display("FAIL abort_park id=%0d grant=%b busy=%b exp=1/010/0", grant_id_o, grant_o, busy_o); end
        ack_i = 1'b0;
    endtask

    task automatic test_timeout();
        pulse_reset();
        req_i = 3'b001;
        step();
        checks++; if (grant_id_o !== 2'd0 || busy_o !== 1'b1) begin failures++; $display("FAIL tmo_grant id=%0d busy=%b exp=0/1", grant_id_o, busy_o); end
        req_i = 3'b101;
`ifdef RIB_ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (busy_o !== 1'b1 || err_o !== 1'b0) begin failures++; $display("FAIL tmo_wait%0d busy=%b err=%b exp=1/0", i, busy_o, err_o); end
        end
        step();
        checks++; if (err_o !== 1'b1 || err_id_o !== 2'd0) begin failures++; $display("FAIL tmo_err err=%b id=%0d exp=1/0", err_o, err_id_o); end
        checks++; if (grant_o !== 3'b010 || busy_o !== 1'b0) begin failures++; $display("FAIL tmo_err_park grant=%b busy=%b exp=010/0", grant_o, busy_o); end
        step();
        checks++; if (err_o !== 1'b0 || busy_o !== 1'b0) begin failures++; $display("FAIL tmo_idle err=%b busy=%b exp=0/0", err_o, busy_o); end
        step();
        checks++; if (grant_id_o !== 2'd2 || busy_o !== 1'b1 || err_id_o !== 2'd0) begin failures++; $display("FAIL tmo_next id=%0d busy=%b err_id=%0d exp=2/1/0", grant_id_o, busy_o, err_id_o); end
`else
        for (int i = 0; i < 300; i++) begin
            step();
            checks++; if (busy_o !== 1'b1 || grant_id_o !== 2'd0 || err_o !== 1'b0) begin failures++; $display("FAIL notmo_wait%0d busy=%b id=%0d err=%b exp=1/0/0", i, busy_o, grant_id_o, err_o); end
        end
`endif
        req_i = 3'b000;
        step();
        step();
        checks++; if (busy_o !== 1'b0 || grant_id_o !== 2'd1) begin failures++; $display("FAIL tmo_release busy=%b id=%0d exp=0/1", busy_o, grant_id_o); end
    endtask

    task automatic test_reset_mid();
        pulse_reset();
        req_i = 3'b100;
        step();
        checks++; if (grant_id_o !== 2'd2) begin failures++; $display("FAIL rstmid_grant id=%0d exp=2", grant_id_o); end
        ack_i = 1'b1; rst = 1'b1;
        #1;
        checks++; if (hold_flag_o !== 1'b0) begin failures++; $display("FAIL rstmid_hold got=%b exp=0", hold_flag_o); end
        step();
        checks++; if (grant_id_o !== 2'd1 || grant_o !== 3'b010) begin failures++; $display("FAIL rstmid_park id=%0d grant=%b exp=1/010", grant_id_o, grant_o); end
        checks++; if (busy_o !== 1'b0 || err_o !== 1'b0) begin failures++; $display("FAIL rstmid_state busy=%b err=%b exp=0/0", busy_o, err_o); end
        rst = 1'b0; ack_i = 1'b0; req_i = 3'b000;
        step();
        checks++; if (busy_o !== 1'b0 || grant_id_o !== 2'd1) begin failures++; $display("FAIL rstmid_after busy=%b id=%0d exp=0/1", busy_o, grant_id_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_park_master();
        test_back_to_back();
        test_abort();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
